// File: rtl/atm_keypad_frontend_pkg.sv
// Shared codes for the keypad front end and the ATM controller:
// operation codes, key codes, entry-state encodings and field widths.
package atm_keypad_frontend_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Operation codes carried on the transaction interface
  localparam logic [2:0] OP_BALANCE    = 3'd1;
  localparam logic [2:0] OP_WITHDRAW   = 3'd2;
  localparam logic [2:0] OP_DEPOSIT    = 3'd3;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
  localparam logic [2:0] OP_EXIT       = 3'd5;

  // Non-digit key codes; 4'hD..4'hF are invalid
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Field widths on the transaction interface
  localparam int OP_W      = 3;
  localparam int ACC_W     = 4;
  localparam int PIN_W     = 16;
  localparam int AMT_W     = 32;
  localparam int AMT_INT_W = 30;   // 999,999,999 < 2^30

  // Session entry states, also shown on the display
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_PIN    = 3'd2,
    ST_OP     = 3'd3,
    ST_AMOUNT = 3'd4,
    ST_NEWPIN = 3'd5,
    ST_SEND   = 3'd6
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Transaction handshake between the keypad front end (master) and the ATM core (slave).
interface atm_keypad_frontend_if;
  import atm_keypad_frontend_pkg::*;

  logic              txn_valid;
  logic              txn_ready;
  logic [OP_W-1:0]   operation;
  logic [ACC_W-1:0]  acc_num;
  logic [PIN_W-1:0]  pin;
  logic [PIN_W-1:0]  new_pin;
  logic [AMT_W-1:0]  amount;

  modport master (
    output txn_valid, operation, acc_num, pin, new_pin, amount,
    input  txn_ready
  );

  modport slave (
    input  txn_valid, operation, acc_num, pin, new_pin, amount,
    output txn_ready
  );

endinterface

// File: rtl/atm_digit_accumulator.sv
// One entry field: accepts up to MAX_DIGITS digits, either shifted in as
// BCD nibbles (DECIMAL=0) or accumulated as a binary decimal value (DECIMAL=1).
module atm_digit_accumulator #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4,
  parameter bit DECIMAL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] value,
  output logic             full
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [CW-1:0] cnt_q;

  assign full = (cnt_q == CW'(MAX_DIGITS));

  // Field value and digit count; a push on a full field is dropped here,
  // the owner flags it as a key error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      value <= '0;
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + 1'b1;
      if (DECIMAL) value <= value * WIDTH'(10) + WIDTH'(digit);
      else         value <= {value[WIDTH-5:0], digit};
    end
  end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad front end of the ATM: sequences a session from keystrokes,
// edits the fields, and offers each finished request on a valid/ready bus.
module atm_keypad_frontend
  import atm_keypad_frontend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int AMOUNT_DIGITS  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  input  logic [3:0]                  key_code,
  atm_keypad_frontend_if.master       txn,
  output logic [2:0]                  entry_state,
  output logic                        key_error,
  output logic                        timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  entry_state_e          state_q, state_d;
  logic [TW-1:0]         timer_q;
  logic [ACC_W-1:0]      acc_num_q;
  logic                  acc_set_q;
  logic [OP_W-1:0]       op_q, op_d;

  logic                  key_err_d, tmo_d, clr_all;
  logic                  acc_ld, acc_clr, op_ld;
  logic                  pin_push, pin_clr, np_push, np_clr, amt_push, amt_clr;
  logic                  pin_full, np_full, amt_full;
  logic [PIN_W-1:0]      pin_val, np_val;
  logic [AMT_INT_W-1:0]  amt_val;
  logic                  in_entry, timer_exp;

  assign in_entry  = (state_q != ST_IDLE) && (state_q != ST_SEND);
  assign timer_exp = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign op_d      = key_code[2:0];

  atm_digit_accumulator #(.WIDTH(PIN_W), .MAX_DIGITS(4), .DECIMAL(1'b0)) u_pin (
    .clk(clk), .rst(rst), .clr(clr_all | pin_clr), .push(pin_push),
    .digit(key_code), .value(pin_val), .full(pin_full)
  );

  atm_digit_accumulator #(.WIDTH(PIN_W), .MAX_DIGITS(4), .DECIMAL(1'b0)) u_new_pin (
    .clk(clk), .rst(rst), .clr(clr_all | np_clr), .push(np_push),
    .digit(key_code), .value(np_val), .full(np_full)
  );

  atm_digit_accumulator #(.WIDTH(AMT_INT_W), .MAX_DIGITS(AMOUNT_DIGITS), .DECIMAL(1'b1)) u_amount (
    .clk(clk), .rst(rst), .clr(clr_all | amt_clr), .push(amt_push),
    .digit(key_code), .value(amt_val), .full(amt_full)
  );

  // Next state and field-edit strobes; CANCEL is checked before any other key
  always_comb begin
    state_d   = state_q;
    key_err_d = FALSE;
    tmo_d     = FALSE;
    clr_all   = FALSE;
    acc_ld    = FALSE;
    acc_clr   = FALSE;
    op_ld     = FALSE;
    pin_push  = FALSE;
    pin_clr   = FALSE;
    np_push   = FALSE;
    np_clr    = FALSE;
    amt_push  = FALSE;
    amt_clr   = FALSE;

    if (key_valid) begin
      if (state_q == ST_SEND) begin
        key_err_d = TRUE;
      end else if (state_q == ST_IDLE) begin
        if (is_digit(key_code)) begin
          acc_ld  = TRUE;
          state_d = ST_ACC;
        end
      end else if (key_code == KEY_CANCEL) begin
        clr_all = TRUE;
        state_d = ST_IDLE;
      end else if (!is_digit(key_code) && key_code != KEY_ENTER && key_code != KEY_CLEAR) begin
        key_err_d = TRUE;
      end else begin
        case (state_q)
          ST_ACC: begin
            if (is_digit(key_code)) begin
              if (acc_set_q) key_err_d = TRUE;
              else           acc_ld    = TRUE;
            end else if (key_code == KEY_ENTER) begin
              if (acc_set_q) begin
                pin_clr = TRUE;
                state_d = ST_PIN;
              end else begin
                key_err_d = TRUE;
              end
            end else begin
              acc_clr = TRUE;
            end
          end
          ST_PIN: begin
            if (is_digit(key_code)) begin
              if (pin_full) key_err_d = TRUE;
              else          pin_push  = TRUE;
            end else if (key_code == KEY_ENTER) begin
              if (pin_full) state_d   = ST_OP;
              else          key_err_d = TRUE;
            end else begin
              pin_clr = TRUE;
            end
          end
          ST_OP: begin
            if (is_digit(key_code) && key_code != 4'd0 && key_code <= 4'd5) begin
              case (op_d)
                OP_BALANCE, OP_EXIT: begin
                  op_ld   = TRUE;
                  state_d = ST_SEND;
                end
                OP_WITHDRAW, OP_DEPOSIT: begin
                  op_ld   = TRUE;
                  amt_clr = TRUE;
                  state_d = ST_AMOUNT;
                end
                OP_CHANGE_PIN: begin
                  op_ld   = TRUE;
                  np_clr  = TRUE;
                  state_d = ST_NEWPIN;
                end
                default: key_err_d = TRUE;
              endcase
            end else if (key_code != KEY_CLEAR) begin
              key_err_d = TRUE;
            end
          end
          ST_AMOUNT: begin
            if (is_digit(key_code)) begin
              if (amt_full) key_err_d = TRUE;
              else          amt_push  = TRUE;
            end else if (key_code == KEY_ENTER) begin
              if (amt_val != '0) state_d   = ST_SEND;
              else               key_err_d = TRUE;
            end else begin
              amt_clr = TRUE;
            end
          end
          ST_NEWPIN: begin
            if (is_digit(key_code)) begin
              if (np_full) key_err_d = TRUE;
              else         np_push   = TRUE;
            end else if (key_code == KEY_ENTER) begin
              if (np_full) state_d   = ST_SEND;
              else         key_err_d = TRUE;
            end else begin
              np_clr = TRUE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (in_entry && timer_exp) begin
      tmo_d   = TRUE;
      clr_all = TRUE;
      state_d = ST_IDLE;
    end

    // Handshake completes regardless of any key in the same cycle
    if (state_q == ST_SEND && txn.txn_ready) begin
      if (op_q == OP_EXIT) begin
        clr_all = TRUE;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_OP;
      end
    end
  end

  // Session state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Inactivity timer: restarts on any key, runs only while a field is being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                timer_q <= '0;
    else if (key_valid || tmo_d || !in_entry) timer_q <= '0;
    else if (!timer_exp)                     timer_q <= timer_q + 1'b1;
  end

  // Account digit, operation and the one-cycle status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_num_q <= '0;
      acc_set_q <= FALSE;
      op_q      <= '0;
      key_error <= FALSE;
      timeout   <= FALSE;
    end else begin
      key_error <= key_err_d;
      timeout   <= tmo_d;
      if (clr_all || acc_clr) begin
        acc_num_q <= '0;
        acc_set_q <= FALSE;
      end else if (acc_ld) begin
        acc_num_q <= key_code;
        acc_set_q <= TRUE;
      end
      if (clr_all)    op_q <= '0;
      else if (op_ld) op_q <= op_d;
    end
  end

  // txn_valid comes straight from the state flop so reset drops it at once
  assign txn.txn_valid = (state_q == ST_SEND);
  assign txn.operation = op_q;
  assign txn.acc_num   = acc_num_q;
  assign txn.pin       = pin_val;
  assign txn.new_pin   = np_val;
  assign txn.amount    = {{(AMT_W - AMT_INT_W){1'b0}}, amt_val};
  assign entry_state   = state_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for the ATM keypad front end.
module tb_atm_keypad_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [2:0] entry_state;
  logic       key_error;
  logic       timeout;
  int         checks = 0;
  int         passed = 0;

  atm_keypad_frontend_if bus();

  atm_keypad_frontend #(.TIMEOUT_CYCLES(20), .AMOUNT_DIGITS(6)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .txn(bus), .entry_state(entry_state), .key_error(key_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic go_to_op();
    press(4'd3); press(4'hA);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
  endtask

  task automatic test_reset();
    bus.txn_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (entry_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", entry_state); else passed++;
    checks++; if (bus.txn_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.txn_valid); else passed++;
    checks++; if ({key_error, timeout} !== 2'b00) $display("FAIL reset_pulses: got %0b want 0", {key_error, timeout}); else passed++;
    checks++; if ({bus.pin, bus.new_pin, bus.amount, bus.acc_num, bus.operation} !== '0) $display("FAIL reset_fields: got nonzero want 0"); else passed++;
    rst = 1'b1;
  endtask

  task automatic test_idle_keys();
    press(4'hA);
    checks++; if ({entry_state, key_error} !== {3'd0, 1'b0}) $display("FAIL idle_enter: got st=%0d err=%0b want st=0 err=0", entry_state, key_error); else passed++;
    press(4'hE);
    checks++; if ({entry_state, key_error} !== {3'd0, 1'b0}) $display("FAIL idle_invalid: got st=%0d err=%0b want st=0 err=0", entry_state, key_error); else passed++;
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.txn_ready = 1'b1;
    go_to_op();
    press(4'd2); press(4'd5); press(4'd0); press(4'd0); press(4'hA);
    checks++; if (bus.txn_valid !== 1'b1) $display("FAIL wd_valid: got %0b want 1", bus.txn_valid); else passed++;
    checks++; if (bus.acc_num !== 4'd3) $display("FAIL wd_acc: got %0d want 3", bus.acc_num); else passed++;
    checks++; if (bus.pin !== 16'h1234) $display("FAIL wd_pin: got %0h want 1234", bus.pin); else passed++;
    checks++; if (bus.operation !== 3'd2) $display("FAIL wd_op: got %0d want 2", bus.operation); else passed++;
    checks++; if (bus.amount !== 32'd500) $display("FAIL wd_amount: got %0d want 500", bus.amount); else passed++;
    @(negedge clk);
    checks++; if ({bus.txn_valid, entry_state} !== {1'b0, 3'd3}) $display("FAIL wd_after: got v=%0b st=%0d want v=0 st=3", bus.txn_valid, entry_state); else passed++;
    checks++; if ({bus.acc_num, bus.pin} !== {4'd3, 16'h1234}) $display("FAIL wd_retain: got acc=%0d pin=%0h want acc=3 pin=1234", bus.acc_num, bus.pin); else passed++;
    bus.txn_ready = 1'b0;
  endtask

  task automatic test_short_pin();
    do_reset();
    press(4'd3); press(4'hA);
    checks++; if (entry_state !== 3'd2) $display("FAIL sp_to_pin: got %0d want 2", entry_state); else passed++;
    press(4'd1); press(4'd2); press(4'd3); press(4'hA);
    checks++; if ({key_error, entry_state} !== {1'b1, 3'd2}) $display("FAIL sp_short_enter: got err=%0b st=%0d want err=1 st=2", key_error, entry_state); else passed++;
    press(4'd4);
    checks++; if ({key_error, bus.pin} !== {1'b0, 16'h1234}) $display("FAIL sp_4th: got err=%0b pin=%0h want err=0 pin=1234", key_error, bus.pin); else passed++;
    press(4'd5);
    checks++; if ({key_error, bus.pin} !== {1'b1, 16'h1234}) $display("FAIL sp_5th: got err=%0b pin=%0h want err=1 pin=1234", key_error, bus.pin); else passed++;
    press(4'hE);
    checks++; if (key_error !== 1'b1) $display("FAIL sp_invalid: got %0b want 1", key_error); else passed++;
    press(4'hA);
    checks++; if ({key_error, entry_state} !== {1'b0, 3'd3}) $display("FAIL sp_to_op: got err=%0b st=%0d want err=0 st=3", key_error, entry_state); else passed++;
    press(4'd6);
    checks++; if ({key_error, entry_state} !== {1'b1, 3'd3}) $display("FAIL op_bad_digit: got err=%0b st=%0d want err=1 st=3", key_error, entry_state); else passed++;
    press(4'hB);
    checks++; if ({key_error, entry_state} !== {1'b0, 3'd3}) $display("FAIL op_clear: got err=%0b st=%0d want err=0 st=3", key_error, entry_state); else passed++;
  endtask

  task automatic test_amount_and_send_hold();
    do_reset();
    bus.txn_ready = 1'b0;
    go_to_op();
    press(4'd2);
    checks++; if ({entry_state, bus.amount} !== {3'd4, 32'd0}) $display("FAIL amt_enter: got st=%0d amt=%0d want st=4 amt=0", entry_state, bus.amount); else passed++;
    press(4'hA);
    checks++; if ({key_error, entry_state} !== {1'b1, 3'd4}) $display("FAIL amt_zero_enter: got err=%0b st=%0d want err=1 st=4", key_error, entry_state); else passed++;
    for (int d = 1; d <= 6; d++) press(4'(d));
    checks++; if ({key_error, bus.amount} !== {1'b0, 32'd123456}) $display("FAIL amt_6dig: got err=%0b amt=%0d want err=0 amt=123456", key_error, bus.amount); else passed++;
    press(4'd7);
    checks++; if ({key_error, bus.amount} !== {1'b1, 32'd123456}) $display("FAIL amt_7th: got err=%0b amt=%0d want err=1 amt=123456", key_error, bus.amount); else passed++;
    press(4'hA);
    checks++; if ({bus.txn_valid, entry_state} !== {1'b1, 3'd6}) $display("FAIL amt_send: got v=%0b st=%0d want v=1 st=6", bus.txn_valid, entry_state); else passed++;
    for (int i = 0; i < 5; i++) begin
      press(4'(i));
      checks++; if ({key_error, bus.txn_valid} !== 2'b11) $display("FAIL hold_key%0d: got err=%0b v=%0b want err=1 v=1", i, key_error, bus.txn_valid); else passed++;
      @(negedge clk);
      checks++; if ({key_error, bus.txn_valid} !== 2'b01) $display("FAIL hold_gap%0d: got err=%0b v=%0b want err=0 v=1", i, key_error, bus.txn_valid); else passed++;
    end
    checks++; if ({bus.acc_num, bus.pin, bus.operation, bus.amount} !== {4'd3, 16'h1234, 3'd2, 32'd123456}) $display("FAIL hold_fields: got acc=%0d pin=%0h op=%0d amt=%0d", bus.acc_num, bus.pin, bus.operation, bus.amount); else passed++;
    bus.txn_ready = 1'b1;
    @(negedge clk);
    bus.txn_ready = 1'b0;
    checks++; if ({bus.txn_valid, entry_state} !== {1'b0, 3'd3}) $display("FAIL hold_handshake: got v=%0b st=%0d want v=0 st=3", bus.txn_valid, entry_state); else passed++;
    press(4'd3); press(4'd7); press(4'hB);
    checks++; if ({entry_state, bus.amount, bus.operation} !== {3'd4, 32'd0, 3'd3}) $display("FAIL amt_clear: got st=%0d amt=%0d op=%0d want st=4 amt=0 op=3", entry_state, bus.amount, bus.operation); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    press(4'd3); press(4'hA); press(4'd1); press(4'd2);
    repeat (19) @(negedge clk);
    checks++; if ({timeout, entry_state} !== {1'b0, 3'd2}) $display("FAIL tmo_early: got tmo=%0b st=%0d want tmo=0 st=2", timeout, entry_state); else passed++;
    @(negedge clk);
    checks++; if ({timeout, entry_state} !== {1'b1, 3'd0}) $display("FAIL tmo_fire: got tmo=%0b st=%0d want tmo=1 st=0", timeout, entry_state); else passed++;
    checks++; if ({bus.pin, bus.acc_num} !== '0) $display("FAIL tmo_clear: got pin=%0h acc=%0d want 0", bus.pin, bus.acc_num); else passed++;
    @(negedge clk);
    checks++; if (timeout !== 1'b0) $display("FAIL tmo_pulse: got %0b want 0", timeout); else passed++;
  endtask

  task automatic test_cancel_newpin();
    do_reset();
    go_to_op();
    press(4'd4);
    checks++; if ({entry_state, bus.operation} !== {3'd5, 3'd4}) $display("FAIL np_enter: got st=%0d op=%0d want st=5 op=4", entry_state, bus.operation); else passed++;
    press(4'd9); press(4'd8);
    checks++; if (bus.new_pin !== 16'h0098) $display("FAIL np_digits: got %0h want 0098", bus.new_pin); else passed++;
    press(4'hB);
    checks++; if ({entry_state, bus.new_pin} !== {3'd5, 16'h0}) $display("FAIL np_clear: got st=%0d np=%0h want st=5 np=0", entry_state, bus.new_pin); else passed++;
    press(4'd7); press(4'hC);
    checks++; if (entry_state !== 3'd0) $display("FAIL cancel_state: got %0d want 0", entry_state); else passed++;
    checks++; if ({bus.acc_num, bus.pin, bus.new_pin, bus.operation, bus.amount} !== '0) $display("FAIL cancel_fields: got nonzero want 0"); else passed++;
  endtask

  task automatic test_exit();
    do_reset();
    bus.txn_ready = 1'b1;
    go_to_op();
    press(4'd5);
    checks++; if ({bus.txn_valid, bus.operation} !== {1'b1, 3'd5}) $display("FAIL exit_send: got v=%0b op=%0d want v=1 op=5", bus.txn_valid, bus.operation); else passed++;
    @(negedge clk);
    checks++; if ({entry_state, bus.acc_num, bus.pin, bus.operation} !== '0) $display("FAIL exit_idle: got st=%0d acc=%0d pin=%0h op=%0d want 0", entry_state, bus.acc_num, bus.pin, bus.operation); else passed++;
    bus.txn_ready = 1'b0;
  endtask

  task automatic test_reset_in_send();
    do_reset();
    go_to_op();
    press(4'd1);
    checks++; if ({bus.txn_valid, bus.operation} !== {1'b1, 3'd1}) $display("FAIL rs_send: got v=%0b op=%0d want v=1 op=1", bus.txn_valid, bus.operation); else passed++;
    rst = 1'b0;
    #1;
    checks++; if ({bus.txn_valid, entry_state, bus.pin} !== '0) $display("FAIL rs_async: got v=%0b st=%0d pin=%0h want 0", bus.txn_valid, entry_state, bus.pin); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.txn_ready = 1'b0;
    test_reset();
    test_idle_keys();
    test_withdraw();
    test_short_pin();
    test_amount_and_send_hold();
    test_timeout();
    test_cancel_newpin();
    test_exit();
    test_reset_in_send();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
